instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of entries in the prefetch FIFO; only powers of two in the range 2..8 are legal.
REQ-002 Parameter ADDR_W, default 5, SHALL set the program-counter width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 fetch_en  input  1  SHALL permit issue of new memory requests while high.
REQ-006 jmp_en  input  1  SHALL request a redirect of the fetch stream, as a one-cycle strobe.
REQ-007 jmp_addr  input  ADDR_W  SHALL be the redirect target, sampled when jmp_en=1.
REQ-008 mem_req  output  1  SHALL be the program-memory read strobe.
REQ-009 mem_addr  output  ADDR_W  SHALL be the read address, valid when mem_req=1.
REQ-010 mem_rvalid  input  1  SHALL mark return data, one cycle after mem_req.
REQ-011 mem_rdata  input  16  SHALL carry the instruction word, in the format {R1,R0 sel[13:12], code[11:8], data[7:0]}.
REQ-012 instr_valid  output  1  SHALL indicate that the FIFO head is presented to the decoder.
REQ-013 instr_data  output  16  SHALL be the FIFO-head instruction word.
REQ-014 instr_pc  output  ADDR_W  SHALL be the address the FIFO-head word was fetched from.
REQ-015 instr_ready  input  1  SHALL be the decoder accept signal; a pop occurs when instr_valid and instr_ready are both 1.
REQ-016 err_sticky  output  1  SHALL flag a protocol error, held until reset.

Function
REQ-017 The FSM SHALL have three states with these transitions:
- IDLE: entered from reset, or whenever fetch_en=0.
- FETCH: entered when fetch_en=1 and credit>0.
- FULL: entered when fetch_en=1 and credit=0.
REQ-018 The block SHALL compute credit = DEPTH - count - inflight, where count is FIFO occupancy and inflight (0/1) marks a request issued in the previous cycle.
REQ-019 The block SHALL assert mem_req=1 with mem_addr=pc only in FETCH with jmp_en=0; pc SHALL then increment modulo 2^ADDR_W, so 31 wraps to 0.
REQ-020 A pop in the same cycle SHALL NOT add credit; credit is recomputed from registered count next cycle.
REQ-021 When mem_rvalid=1 and jmp_en=0, the block SHALL push {mem_rdata, address of that request} into the FIFO; the word is visible on instr_valid/instr_data/instr_pc in the following cycle.
REQ-022 Latency from mem_req to instr_valid SHALL be 2 cycles; sustained throughput SHALL be 1 word/cycle when instr_ready=1 and DEPTH>=4.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-024 When instr_valid=0, instr_data and instr_pc SHALL be driven to 0.
REQ-025 On jmp_en=1, in a single cycle, the block SHALL:
- flush the FIFO (count<=0, pointers <=0);
- discard any mem_rvalid arriving that cycle;
- issue no request;
- set pc<=jmp_addr;
- clear inflight;
- ignore any pop that cycle.
REQ-026 After jmp_en, the first request to jmp_addr SHALL be issued in the next cycle if fetch_en=1.
REQ-027 When jmp_en and rst are both high, reset SHALL take priority.
REQ-028 When fetch_en falls, the block SHALL stop new requests, still accept the outstanding response, and keep presenting FIFO contents.
REQ-029 The block SHALL set err_sticky when mem_rvalid=1 with inflight=0 and jmp_en=0, or when a push would exceed DEPTH; the offending word SHALL be dropped.

Reset
REQ-030 While rst=1, the block SHALL hold these values, and first leave IDLE in the cycle after rst falls:
- pc=0, count=0, inflight=0, state=IDLE;
- mem_req=0, mem_addr=0;
- instr_valid=0, instr_data=0, instr_pc=0;
- err_sticky=0.
REQ-031 Reset mid-operation SHALL discard FIFO contents and any in-flight response; mem_rvalid during the rst=1 cycle SHALL be ignored without setting err_sticky.

Verification
REQ-032 Streaming: rst low, fetch_en=1, instr_ready=1, memory returns 16'h0A05 at addr 1 -> mem_req in cycles 0..N with addr 0,1,2...; instr_valid from cycle 2; instr_pc=1 carries 16'h0A05.
REQ-033 Backpressure: instr_ready=0 with DEPTH=4 -> exactly 4 requests (addr 0..3); state FULL; mem_req=0 until the first pop, then a single request to addr 4.
REQ-034 Wrap: jmp_addr=30, then stream -> fetch order 30,31,0,1; instr_pc follows the same order.
REQ-035 Redirect with in-flight response: jmp_en=1 to addr 7 in the cycle mem_rvalid returns addr 3 data -> that word is dropped; FIFO is empty next cycle; the next mem_addr=7; the first delivered instr_pc=7; err_sticky stays 0.
REQ-036 Protocol error: mem_rvalid=1 with no request outstanding -> err_sticky=1 next cycle and held; count unchanged; rst=1 clears it to 0.
REQ-037 Mid-stream reset: rst=1 for 1 cycle with 3 words buffered -> instr_valid=0 next cycle; a new fetch begins at addr 0.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction prefetch unit with credit-limited memory requests
// Fetches program words into a small FIFO and presents the head to the decoder.
module instr_fetch #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic              instr_valid,
    output logic [15:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              err_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 16 + ADDR_W;
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              err_q, err_d;
    logic [ENT_W-1:0]  fifo_q [DEPTH];

    logic              pop;
    logic              push;
    logic              rv_ok;
    logic              rv_bad;
    logic              fifo_full;
    logic [CNT_W:0]    credit_next;
    logic [ENT_W-1:0]  head;

    assign mem_req     = (state_q == FETCH) && !jmp_en && !rst;
    assign mem_addr    = mem_req ? pc_q : '0;
    assign instr_valid = (count_q != '0) && !rst;
    assign head        = fifo_q[rd_ptr_q];
    assign instr_data  = instr_valid ? head[ENT_W-1:ADDR_W] : '0;
    assign instr_pc    = instr_valid ? head[ADDR_W-1:0] : '0;
    assign err_sticky  = err_q && !rst;

    // A full FIFO can still take the returning word when the head leaves this cycle.
    assign fifo_full = (count_q == DEPTH_CNT);
    assign pop       = instr_valid && instr_ready && !jmp_en;
    assign rv_ok     = mem_rvalid && !jmp_en && !rst;
    assign push      = rv_ok && inflight_q && (!fifo_full || pop);
    assign rv_bad    = rv_ok && (!inflight_q || (fifo_full && !pop));

    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        inflight_d = mem_req;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q || rv_bad;

        if (mem_req) begin
            pc_d       = pc_q + ADDR_W'(1);
            req_addr_d = pc_q;
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (jmp_en) begin
            pc_d       = jmp_addr;
            inflight_d = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end

        // Credit is judged on the occupancy the next cycle will see, so a request
        // issued now is already counted and the FIFO can never be oversubscribed.
        credit_next = DEPTH_EXT - ({1'b0, count_d} + {{CNT_W{1'b0}}, inflight_d});
        if (!fetch_en)
            state_d = IDLE;
        else if (credit_next != '0)
            state_d = FETCH;
        else
            state_d = FULL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {mem_rdata, req_addr_q};
    end

endmodule
